// File: rtl/lcd_text_ctrl.sv
// HD44780 character-LCD text controller.
// Runs the power-up wait, wake and configuration sequence once after reset, then writes a
// full LINE_CHARS x NUM_LINES frame on each accepted start. Later frames skip straight to
// addressing. Handles nibble/byte sequencing, the E strobe and every command delay.
// Optional feature: define LCD_CHAR_FILTER_EN to send non-printable data bytes as spaces.
module lcd_text_ctrl #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BUS_WIDTH  = 4,
  parameter int unsigned LINE_CHARS = 16,
  parameter int unsigned NUM_LINES  = 2
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic                                start,
  input  logic [8*LINE_CHARS*NUM_LINES-1:0]   text,
  output logic                                busy,
  output logic                                done,
  output logic                                LCD_RS,
  output logic                                LCD_E,
  output logic [BUS_WIDTH-1:0]                LCD_D
);

  localparam int unsigned T_US  = (CLK_FREQ / 1000000 < 1) ? 1 : CLK_FREQ / 1000000;
  localparam int unsigned E_CYC = (CLK_FREQ / 2000000 < 1) ? 1 : CLK_FREQ / 2000000;
  localparam int unsigned CW    = $clog2(15000 * T_US + 1);
  localparam int unsigned TW    = 8 * LINE_CHARS * NUM_LINES;
  localparam logic        BUS8  = (BUS_WIDTH == 8);

  // Counter reload values are (cycles - 1) so a wait ends on the cycle cnt reaches zero.
  localparam logic [CW-1:0] PWR_LD  = CW'(15000 * T_US - 1);
  localparam logic [CW-1:0] D4100   = CW'(4100 * T_US - 1);
  localparam logic [CW-1:0] D3000   = CW'(3000 * T_US - 1);
  localparam logic [CW-1:0] D100    = CW'(100 * T_US - 1);
  localparam logic [CW-1:0] D53     = CW'(53 * T_US - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(T_US - 1);
  localparam logic [CW-1:0] E_LD    = CW'(E_CYC - 1);
  localparam logic [7:0]    FUNC_SET = 8'h20 | (BUS8 ? 8'h10 : 8'h00) |
                                       ((NUM_LINES == 2) ? 8'h08 : 8'h00);

  typedef enum logic [2:0] {IDLE, PWRUP, WAKE, CFG, ADDR, CHARS, FIN} state_t;
  typedef enum logic [1:0] {PH_LOAD, PH_SETUP, PH_HIGH, PH_WAIT} phase_t;

  state_t          state;
  phase_t          phase;
  logic [CW-1:0]   cnt;
  logic [5:0]      idx;
  logic            line;
  logic            second;
  logic            initOk;
  logic [TW-1:0]   textReg;

  logic            itemRs;
  logic [7:0]      itemByte;
  logic            itemSingle;
  logic [CW-1:0]   itemDly;
  logic [5:0]      lastIdx;
  logic [7:0]      rawChar;
  logic [7:0]      charByte;
  logic [3:0]      nib;
  logic            firstHalf;
  logic [BUS_WIDTH-1:0] wordVal;

  // Describe the current bus item (command/data byte, wake nibble) and its post delay.
  always_comb begin
    itemRs     = 1'b0;
    itemByte   = 8'h00;
    itemSingle = 1'b0;
    itemDly    = D53;
    lastIdx    = 6'd0;
    rawChar    = textReg[TW-1 -: 8];
`ifdef LCD_CHAR_FILTER_EN
    charByte   = (rawChar < 8'h20 || rawChar > 8'h7E) ? 8'h20 : rawChar;
`else
    charByte   = rawChar;
`endif
    case (state)
      WAKE: begin
        itemSingle = 1'b1;
        itemByte   = BUS8 ? 8'h30 : ((idx == 6'd3) ? 8'h02 : 8'h03);
        itemDly    = (idx == 6'd0) ? D4100 : D100;
        lastIdx    = BUS8 ? 6'd2 : 6'd3;
      end
      CFG: begin
        lastIdx = 6'd4;
        case (idx)
          6'd0:    itemByte = FUNC_SET;
          6'd1:    itemByte = 8'h08;
          6'd2:    begin itemByte = 8'h01; itemDly = D3000; end
          6'd3:    itemByte = 8'h06;
          default: itemByte = 8'h0C;
        endcase
      end
      ADDR:  itemByte = line ? 8'hC0 : 8'h80;
      CHARS: begin
        itemRs   = 1'b1;
        itemByte = charByte;
        lastIdx  = 6'(LINE_CHARS - 1);
      end
      default: ;
    endcase
    firstHalf = !BUS8 && !itemSingle && !second;
    nib       = (itemSingle || second) ? itemByte[3:0] : itemByte[7:4];
    wordVal   = BUS8 ? itemByte[BUS_WIDTH-1:0] : BUS_WIDTH'(nib);
  end

  // Frame sequencer: state walk, per-word strobe phases and delay counting.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      phase   <= PH_LOAD;
      cnt     <= '0;
      idx     <= '0;
      line    <= 1'b0;
      second  <= 1'b0;
      initOk  <= 1'b0;
      textReg <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      LCD_RS  <= 1'b0;
      LCD_E   <= 1'b0;
      LCD_D   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // done is still high in the cycle after FIN, which blocks a start in that cycle.
          if (start && !done) begin
            textReg <= text;
            busy    <= 1'b1;
            idx     <= '0;
            line    <= 1'b0;
            second  <= 1'b0;
            phase   <= PH_LOAD;
            cnt     <= PWR_LD;
            state   <= initOk ? ADDR : PWRUP;
          end
        end
        PWRUP: begin
          if (cnt == '0) begin
            state  <= WAKE;
            phase  <= PH_LOAD;
            idx    <= '0;
            second <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        WAKE, CFG, ADDR, CHARS: begin
          case (phase)
            PH_LOAD: begin
              LCD_RS <= itemRs;
              LCD_D  <= wordVal;
              cnt    <= E_LD;
              phase  <= PH_SETUP;
            end
            PH_SETUP: begin
              if (cnt == '0) begin
                LCD_E <= 1'b1;
                cnt   <= E_LD;
                phase <= PH_HIGH;
              end else begin
                cnt <= cnt - CW'(1);
              end
            end
            PH_HIGH: begin
              if (cnt == '0) begin
                LCD_E <= 1'b0;
                cnt   <= firstHalf ? GAP_LD : itemDly;
                phase <= PH_WAIT;
              end else begin
                cnt <= cnt - CW'(1);
              end
            end
            default: begin
              if (cnt != '0) begin
                cnt <= cnt - CW'(1);
              end else begin
                phase <= PH_LOAD;
                if (firstHalf) begin
                  second <= 1'b1;
                end else begin
                  second <= 1'b0;
                  // Text is consumed by shifting so the next char is always the top byte.
                  if (state == CHARS) textReg <= textReg << 8;
                  if (idx == lastIdx) begin
                    idx <= '0;
                    case (state)
                      WAKE:    state <= CFG;
                      CFG:     state <= ADDR;
                      ADDR:    state <= CHARS;
                      default: begin
                        if (line == 1'(NUM_LINES - 1)) begin
                          state <= FIN;
                        end else begin
                          line  <= 1'b1;
                          state <= ADDR;
                        end
                      end
                    endcase
                  end else begin
                    idx <= idx + 6'd1;
                  end
                end
              end
            end
          endcase
        end
        FIN: begin
          done   <= 1'b1;
          busy   <= 1'b0;
          initOk <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Testbench for lcd_text_ctrl: a 4-bit and an 8-bit 16x2 instance at 1 MHz (T_US = E_CYC = 1).
// Expected bus words come from a command-list model of the LCD protocol; captured E strobes
// are compared word by word along with strobe width, post-delay and first-pulse latency.
module tb_lcd_text_ctrl;

  localparam int TW = 256;

  typedef struct {logic rs; logic [7:0] d; int rise; int fall;} cap_t;
  typedef struct {logic rs; logic [7:0] d; int dly;} exp_t;

  logic          CLK = 1'b0;
  logic          RST;
  logic          start4, start8;
  logic [TW-1:0] text4, text8;
  logic          busy4, done4, rs4, e4;
  logic          busy8, done8, rs8, e8;
  logic [3:0]    d4;
  logic [7:0]    d8;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int startCyc;
  cap_t cap4[$];
  cap_t cap8[$];
  exp_t expQ[$];
  int done4Cnt = 0, done8Cnt = 0, done4Cyc = 0, done8Cyc = 0;
  logic prevE4 = 1'b0, prevE8 = 1'b0;

  lcd_text_ctrl #(.CLK_FREQ(1000000), .BUS_WIDTH(4), .LINE_CHARS(16), .NUM_LINES(2)) u4 (
    .CLK(CLK), .RST(RST), .start(start4), .text(text4), .busy(busy4), .done(done4),
    .LCD_RS(rs4), .LCD_E(e4), .LCD_D(d4));

  lcd_text_ctrl #(.CLK_FREQ(1000000), .BUS_WIDTH(8), .LINE_CHARS(16), .NUM_LINES(2)) u8 (
    .CLK(CLK), .RST(RST), .start(start8), .text(text8), .busy(busy8), .done(done8),
    .LCD_RS(rs8), .LCD_E(e8), .LCD_D(d8));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Bus monitor: record every E strobe (word, rise and fall cycle) and every done pulse.
  always @(negedge CLK) begin
    cap_t c;
    if (e4 && !prevE4) begin
      c.rs = rs4; c.d = {4'h0, d4}; c.rise = cyc; c.fall = 0;
      cap4.push_back(c);
    end
    if (!e4 && prevE4 && cap4.size() > 0) cap4[cap4.size()-1].fall = cyc;
    if (e8 && !prevE8) begin
      c.rs = rs8; c.d = d8; c.rise = cyc; c.fall = 0;
      cap8.push_back(c);
    end
    if (!e8 && prevE8 && cap8.size() > 0) cap8[cap8.size()-1].fall = cyc;
    prevE4 = e4;
    prevE8 = e8;
    if (done4) begin done4Cnt++; done4Cyc = cyc; end
    if (done8) begin done8Cnt++; done8Cyc = cyc; end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] filt(input logic [7:0] c);
`ifdef LCD_CHAR_FILTER_EN
    return (c < 8'h20 || c > 8'h7E) ? 8'h20 : c;
`else
    return c;
`endif
  endfunction

  task automatic pushWord(input logic rs, input logic [7:0] d, input int dly);
    exp_t w;
    w.rs = rs; w.d = d; w.dly = dly;
    expQ.push_back(w);
  endtask

  task automatic pushByte(input int bus, input logic rs, input logic [7:0] b, input int dly);
    if (bus == 8) begin
      pushWord(rs, b, dly);
    end else begin
      pushWord(rs, {4'h0, b[7:4]}, 1);
      pushWord(rs, {4'h0, b[3:0]}, dly);
    end
  endtask

  // Expected word list for one frame, straight from the HD44780 init and write rules.
  task automatic buildExp(input int bus, input bit full, input logic [TW-1:0] txt);
    logic [7:0] ch;
    expQ.delete();
    if (full) begin
      if (bus == 4) begin
        pushWord(0, 8'h03, 4100); pushWord(0, 8'h03, 100);
        pushWord(0, 8'h03, 100);  pushWord(0, 8'h02, 100);
      end else begin
        pushWord(0, 8'h30, 4100); pushWord(0, 8'h30, 100); pushWord(0, 8'h30, 100);
      end
      pushByte(bus, 0, (bus == 8) ? 8'h38 : 8'h28, 53);
      pushByte(bus, 0, 8'h08, 53);
      pushByte(bus, 0, 8'h01, 3000);
      pushByte(bus, 0, 8'h06, 53);
      pushByte(bus, 0, 8'h0C, 53);
    end
    for (int ln = 0; ln < 2; ln++) begin
      pushByte(bus, 0, (ln == 0) ? 8'h80 : 8'hC0, 53);
      for (int k = 0; k < 16; k++) begin
        ch = txt[TW-1-8*(ln*16+k) -: 8];
        pushByte(bus, 1, filt(ch), 53);
      end
    end
  endtask

  task automatic compareFrame(input string nm, input int which, input int base,
                              input int sCyc, input bit full, input int dCyc);
    cap_t q[$];
    int n, bad, lat, g;
    if (which == 8) begin
      for (int i = base; i < cap8.size(); i++) q.push_back(cap8[i]);
    end else begin
      for (int i = base; i < cap4.size(); i++) q.push_back(cap4[i]);
    end
    check({nm, "_count"}, q.size(), expQ.size());
    n = (q.size() < expQ.size()) ? q.size() : expQ.size();
    bad = 0;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_w%0d", nm, i), {q[i].rs, q[i].d}, {expQ[i].rs, expQ[i].d});
      if (q[i].fall - q[i].rise != 1) bad++;
      if (i + 1 < n) begin
        g = q[i+1].rise - q[i].fall;
        if (g < expQ[i].dly || g > expQ[i].dly + 4) bad++;
      end
    end
    check({nm, "_timing"}, bad, 0);
    if (n > 0) begin
      lat = q[0].rise - sCyc;
      check({nm, "_lat"}, full ? (lat >= 15000 && lat <= 15010) : (lat >= 1 && lat <= 10), 1);
      g = dCyc - q[n-1].fall;
      check({nm, "_donedly"}, (g >= expQ[n-1].dly && g <= expQ[n-1].dly + 4), 1);
    end
  endtask

  function automatic logic [TW-1:0] randText();
    logic [TW-1:0] t;
    for (int k = 0; k < 32; k++) t[TW-1-8*k -: 8] = 8'($urandom_range(0, 255));
    t[TW-1 -: 8]    = 8'h48;
    t[TW-1-40 -: 8] = 8'h0A;
    return t;
  endfunction

  // One frame: start pulse, stray starts while busy and on the done cycle, bounded wait.
  task automatic doFrame(input string nm, input bit use8, input int budget);
    bit fin4, fin8;
    int tail;
    @(negedge CLK);
    start4 = 1'b1; start8 = use8; startCyc = cyc;
    @(negedge CLK);
    start4 = 1'b0; start8 = 1'b0;
    text4 = ~text4; text8 = ~text8;
    check({nm, "_busy4"}, busy4, 1);
    if (use8) check({nm, "_busy8"}, busy8, 1);
    fin4 = 0; fin8 = !use8; tail = 0;
    for (int k = 0; k < budget && tail < 20; k++) begin
      start4 = done4 || (busy4 && (k == 100 || $urandom_range(0, 999) == 0));
      start8 = use8 && (done8 || (busy8 && (k == 100 || $urandom_range(0, 999) == 0)));
      @(negedge CLK);
      if (done4) fin4 = 1;
      if (done8) fin8 = 1;
      if (fin4 && fin8) tail++;
    end
    start4 = 1'b0; start8 = 1'b0;
    check({nm, "_finished"}, tail >= 20, 1);
    check({nm, "_idle4"}, busy4, 0);
  endtask

  initial begin
    logic [TW-1:0] t4, t8;
    int b4, b8, n4, n8;
    bit reached;
    RST = 1'b1; start4 = 1'b0; start8 = 1'b0; text4 = '0; text8 = '0;
    repeat (3) @(negedge CLK);
    check("rst_busy4", busy4, 0); check("rst_done4", done4, 0);
    check("rst_e4", e4, 0);       check("rst_rs4", rs4, 0);  check("rst_d4", d4, 0);
    check("rst_busy8", busy8, 0); check("rst_e8", e8, 0);    check("rst_d8", d8, 0);
    RST = 1'b0;
    @(negedge CLK);

    // Frame 1: full init on both bus widths.
    t4 = randText(); t8 = randText(); text4 = t4; text8 = t8;
    b4 = cap4.size(); b8 = cap8.size(); n4 = done4Cnt; n8 = done8Cnt;
    doFrame("f1", 1, 40000);
    buildExp(4, 1, t4); compareFrame("f1_b4", 4, b4, startCyc, 1, done4Cyc);
    buildExp(8, 1, t8); compareFrame("f1_b8", 8, b8, startCyc, 1, done8Cyc);
    check("f1_dones4", done4Cnt - n4, 1);
    check("f1_dones8", done8Cnt - n8, 1);

    // Frame 2: init already done, straight to addressing.
    t4 = randText(); text4 = t4;
    b4 = cap4.size(); n4 = done4Cnt;
    doFrame("f2", 0, 10000);
    buildExp(4, 0, t4); compareFrame("f2_b4", 4, b4, startCyc, 0, done4Cyc);
    check("f2_dones4", done4Cnt - n4, 1);

    // Frame 3: reset while a data strobe is high.
    text4 = randText();
    b4 = cap4.size(); n4 = done4Cnt;
    @(negedge CLK); start4 = 1'b1;
    @(negedge CLK); start4 = 1'b0;
    reached = 0;
    for (int k = 0; k < 5000 && !reached; k++) begin
      @(negedge CLK);
      if (cap4.size() - b4 >= 12 && e4 && rs4) reached = 1;
    end
    check("f3_reach", reached, 1);
    RST = 1'b1;
    #1;
    check("f3_rst_e4", e4, 0); check("f3_rst_busy4", busy4, 0);
    check("f3_rst_rs4", rs4, 0); check("f3_rst_d4", d4, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    check("f3_dones4", done4Cnt - n4, 0);

    // Frame 4: reset cleared init state, so full init again.
    t4 = randText(); text4 = t4;
    b4 = cap4.size(); n4 = done4Cnt;
    doFrame("f4", 0, 40000);
    buildExp(4, 1, t4); compareFrame("f4_b4", 4, b4, startCyc, 1, done4Cyc);
    check("f4_dones4", done4Cnt - n4, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
